reg_scoreboard: RTL
===================

Name: reg_scoreboard

Overview:
- Parametrised register scoreboard for the in-order 5-stage CPU pipeline. It generalises the per-stage forwarding buses, which cover a fixed ES/MS/WS set, into a counter-based tracker of in-flight register writes.
- Sits beside the ID stage:
  - ID presents each instruction's source and destination registers at issue.
  - WB reports each register write as a retire.
- Produces issue_ready (the stall decision) and per-source busy flags.
- Two modes: stall on any pending writer (no forwarding), or stall only on a pending load (forwarding present).

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register index width; NREG <= 2**AW.
- CW, 3, per-register in-flight counter width; at most 2**CW-1 pending writes per register.
- NSRC, 2, number of source operands checked per issue.
- FWD, 1, 1 = stall only when the youngest pending writer is a load; 0 = stall on any pending writer.
- ZERO_REG, 1, 1 = register 0 is never tracked, never busy, and issue/retire to it are ignored.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- issue_valid  in  1  ID presents an instruction.
- issue_ready  out  1  instruction may issue this cycle.
- issue_src  in  NSRC*AW  source register indices; src k occupies bits [k*AW +: AW].
- issue_src_used  in  NSRC  per-source "operand actually read" flag.
- issue_we  in  1  instruction writes a register.
- issue_dest  in  AW  destination index.
- issue_is_load  in  1  destination is produced by a load.
- retire_valid  in  1  WB commits a register write.
- retire_dest  in  AW  index being retired.
- flush  in  1  synchronous clear of all tracking state.
- src_busy  out  NSRC  per-source "this source causes a stall" flag.
- pending_any  out  1  some register has cnt != 0.
- err  out  1  sticky: retire seen on a register with cnt == 0.

Behaviour:
- State per register r:
  - cnt[r] (CW bits).
  - last_ld[r] (1 bit).
- Reset (resetn low, asynchronous): all cnt = 0, all last_ld = 0, err = 0. Consequently issue_ready = 1 (if flush = 0), src_busy = 0, pending_any = 0.
- Busy evaluation uses registered state only. A retire in cycle t does not unblock an issue in cycle t; the unblock is visible from t+1. There is no same-cycle bypass.
- busy(r):
  - FWD = 0: cnt[r] != 0.
  - FWD = 1: cnt[r] != 0 && last_ld[r].
  - Always 0 when ZERO_REG = 1 and r = 0.
  - Always 0 when r >= NREG.
- src_busy[k] = issue_src_used[k] && busy(src k). This is independent of issue_valid.
- sat = issue_we && cnt[issue_dest] == 2**CW-1 (evaluated against a trackable dest only).
- issue_ready = !flush && !(|src_busy) && !sat.
- Issue fire = issue_valid && issue_ready. On fire with issue_we and a trackable dest:
  - cnt[dest] increments by 1.
  - last_ld[dest] <= issue_is_load.
- Retire (retire_valid, trackable dest):
  - If cnt != 0: cnt decrements by 1; when cnt goes 1 -> 0, last_ld <= 0.
  - If cnt == 0: state is unchanged and err <= 1 (sticky until reset; flush does not clear it).
- Simultaneous issue fire and retire on the same register:
  - cnt is unchanged.
  - last_ld <= issue_is_load.
  - The retire still counts as valid even if cnt was 0: no err, and cnt ends at 0+1-1 = 0.
- Simultaneous issue and retire on different registers: both are applied independently.
- flush = 1 (synchronous):
  - Next cycle all cnt = 0 and all last_ld = 0.
  - issue_ready = 0 in the flush cycle, so a concurrent issue is dropped.
  - A concurrent retire is discarded and does not set err.
- pending_any = OR over all r of (cnt[r] != 0), from registered state.
- All counter arithmetic is CW-bit unsigned. Overflow is impossible because of the sat check; underflow is impossible because of the err path.

Test Plan:
1. Reset / idle: hold resetn = 0 mid-operation with cnt[5] = 2. Expect cnt cleared asynchronously, issue_ready = 1, pending_any = 0, err = 0 before the next clk edge.
2. Load-use, FWD = 1:
   - Issue a load to r8.
   - Next cycle present src0 = 8, used = 1: src_busy = 01, issue_ready = 0.
   - Retire r8: issue_ready = 1 one cycle later, not in the retire cycle.
3. ALU dependency:
   - FWD = 1: issue a non-load to r9, then a reader of r9 → issue_ready = 1.
   - Same sequence with FWD = 0 → issue_ready = 0 until r9 retires.
4. Counter saturation, CW = 2: issue three writes to r3 (cnt = 3). A fourth write to r3 gives issue_ready = 0. One retire → cnt = 2, and the fourth issue fires.
5. Corner cases:
   - Issue and retire r4 in the same cycle with cnt = 1: cnt stays 1, last_ld follows issue_is_load.
   - Retire r6 with cnt = 0: err = 1 and stays 1.
   - Issue/retire to r0 with ZERO_REG = 1: no state change.
6. Flush:
   - With cnt[2] = 1 and cnt[7] = 3, assert flush together with issue_valid on r2.
   - Expect the issue dropped and all cnt = 0 next cycle (pending_any = 0).
   - err is unchanged.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard for the in-order pipeline: per-register in-flight write counters
// decide whether an instruction at ID may issue, with or without forwarding.
module reg_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int CW       = 3,
  parameter int NSRC     = 2,
  parameter bit FWD      = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [NSRC*AW-1:0] issue_src,
  input  logic [NSRC-1:0]    issue_src_used,
  input  logic               issue_we,
  input  logic [AW-1:0]      issue_dest,
  input  logic               issue_is_load,
  input  logic               retire_valid,
  input  logic [AW-1:0]      retire_dest,
  input  logic               flush,
  output logic [NSRC-1:0]    src_busy,
  output logic               pending_any,
  output logic               err
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  function automatic logic [NREG-1:0] track_mask();
    logic [NREG-1:0] m;
    m = '1;
    if (ZERO_REG) m[0] = 1'b0;
    return m;
  endfunction

  localparam logic [NREG-1:0] TRACK = track_mask();

  logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]         last_ld_q, last_ld_d;
  logic                    err_q, err_d;

  logic [NREG-1:0] cnt_nz, cnt_full, busy_r, iss_hit, ret_hit, inc_hit;
  logic            sat, fire;

  // Indices at or above NREG never match any r, so they are naturally untracked.
  always_comb begin
    cnt_nz   = '0;
    cnt_full = '0;
    busy_r   = '0;
    iss_hit  = '0;
    ret_hit  = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nz[r]   = (cnt_q[r] != '0);
      cnt_full[r] = (cnt_q[r] == CNT_MAX);
      busy_r[r]   = TRACK[r] && cnt_nz[r] && (!FWD || last_ld_q[r]);
      iss_hit[r]  = TRACK[r] && issue_we && (issue_dest == AW'(r));
      ret_hit[r]  = TRACK[r] && retire_valid && (retire_dest == AW'(r));
    end
  end

  always_comb begin
    src_busy = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int r = 0; r < NREG; r++) begin
        if (issue_src[k*AW +: AW] == AW'(r) && busy_r[r]) src_busy[k] = 1'b1;
      end
      src_busy[k] = src_busy[k] && issue_src_used[k];
    end
  end

  assign sat         = |(iss_hit & cnt_full);
  assign issue_ready = !flush && !(|src_busy) && !sat;
  assign fire        = issue_valid && issue_ready;
  assign inc_hit     = {NREG{fire}} & iss_hit;

  // A same-cycle issue and retire on one register cancel; the retire is never an error then.
  always_comb begin
    cnt_d     = cnt_q;
    last_ld_d = last_ld_q;
    err_d     = err_q;
    if (flush) begin
      cnt_d     = '0;
      last_ld_d = '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_hit[r] && ret_hit[r]) begin
          last_ld_d[r] = issue_is_load;
        end else if (inc_hit[r]) begin
          cnt_d[r]     = cnt_q[r] + CW'(1);
          last_ld_d[r] = issue_is_load;
        end else if (ret_hit[r]) begin
          if (cnt_nz[r]) begin
            cnt_d[r] = cnt_q[r] - CW'(1);
            if (cnt_q[r] == CW'(1)) last_ld_d[r] = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      last_ld_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      last_ld_q <= last_ld_d;
      err_q     <= err_d;
    end
  end

  assign pending_any = |cnt_nz;
  assign err         = err_q;

endmodule
